// File: rtl/timer_dev_pkg.sv
// Shared encodings for the timer device: register offsets, CTRL layout,
// mode codes and FSM state encoding.
package timer_dev_pkg;

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_PRESET = 2'd1;
  localparam logic [1:0] A_COUNT  = 2'd2;
  localparam logic [1:0] A_RSVD   = 2'd3;

  localparam logic [1:0] MODE_AUTO = 2'b01;

  // CTRL[3]=IM, CTRL[2:1]=Mode, CTRL[0]=Enable
  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } ctrl_t;

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, CNT = 2'd2, INT = 2'd3} state_t;

  // Mode codes 1x fall back to one-shot behaviour.
  function automatic logic is_auto(ctrl_t c);
    return c.mode == MODE_AUTO;
  endfunction

endpackage

// File: rtl/timer_dev.sv
// Bus-mapped down-counting timer: CTRL/PRESET/COUNT register file, count FSM
// and a maskable interrupt, all in one module.
module timer_dev
  import timer_dev_pkg::*;
#(
  parameter logic [31:0] PRESET_RST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  Addr,
  input  logic        We,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  state_t      state, nxt;
  ctrl_t       ctrl;
  logic [31:0] preset, count;
  logic        pend;

  logic ctrl_wr, stop;
  logic load, dec, set_pend, clr_pend, clr_en;

  assign ctrl_wr = We && (Addr == A_CTRL);
  assign stop    = ctrl_wr && !Din[0];

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (ctrl.en) nxt = LOAD;
      LOAD:    nxt = CNT;
      CNT:     if (count == '0) nxt = INT;
      INT:     nxt = is_auto(ctrl) ? LOAD : IDLE;
      default: nxt = IDLE;
    endcase
    // Software disable overrides whatever the FSM wanted to do.
    if (stop) nxt = IDLE;
  end

  always_comb begin
    load     = (state == LOAD) && !stop;
    dec      = (state == CNT) && (count != '0) && !stop;
    set_pend = (nxt == INT);
    clr_pend = ctrl_wr || ((state == INT) && (nxt == LOAD));
    clr_en   = (state == INT) && !is_auto(ctrl);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ctrl   <= '0;
      preset <= PRESET_RST;
      count  <= '0;
      pend   <= 1'b0;
    end else begin
      // A CTRL write wins over the one-shot Enable clear.
      if (ctrl_wr)     ctrl    <= ctrl_t'(Din[3:0]);
      else if (clr_en) ctrl.en <= 1'b0;

      if (We && (Addr == A_PRESET)) preset <= Din;

      if (load)     count <= preset;
      else if (dec) count <= count - 32'd1;

      if (set_pend)      pend <= 1'b1;
      else if (clr_pend) pend <= 1'b0;
    end
  end

  assign IRQ = pend & ctrl.im;

  always_comb begin
    case (Addr)
      A_CTRL:   Dout = {28'b0, ctrl};
      A_PRESET: Dout = preset;
      A_COUNT:  Dout = count;
      A_RSVD:   Dout = '0;
      default:  Dout = '0;
    endcase
  end

endmodule
